// File: rtl/rv_pipe_pkg.sv
// Purpose: shared pipeline types and constants for the RV pipeline boundary registers.
// Contents: datapath widths, load-type codes, and the EX->MEM payload bundle.
package rv_pipe_pkg;

   localparam int unsigned XLEN    = 32;
   localparam int unsigned RADDR_W = 5;
   localparam int unsigned LDT_W   = 3;

   // Load-type codes carried alongside loads into MEM
   localparam logic [LDT_W-1:0] LDT_LB  = LDT_W'(0);
   localparam logic [LDT_W-1:0] LDT_LH  = LDT_W'(1);
   localparam logic [LDT_W-1:0] LDT_LW  = LDT_W'(2);
   localparam logic [LDT_W-1:0] LDT_LBU = LDT_W'(4);
   localparam logic [LDT_W-1:0] LDT_LHU = LDT_W'(5);

   // EX->MEM payload: ALU result, store data and control bundle of one instruction
   typedef struct packed {
      logic [XLEN-1:0]    alu;
      logic [XLEN-1:0]    rs2;
      logic [XLEN-1:0]    pc;
      logic [RADDR_W-1:0] rd;
      logic               rd_wren;
      logic               mem_wren;
      logic               mem_rden;
      logic [LDT_W-1:0]   ld_type;
   } ex_mem_pl_t;

endpackage

// File: rtl/ex_mem_skid_reg_if.sv
// Purpose: EX->MEM boundary bus (EX handshake + payload in, MEM handshake + payload out,
//          forwarding tap, flush).
// Modports: slave  - the boundary register (consumes i_*, drives o_*)
//           master - the surrounding pipeline (drives i_*, consumes o_*)
interface ex_mem_skid_reg_if;
   import rv_pipe_pkg::*;

   logic               i_flush;
   logic               i_ex_valid;
   logic               o_ex_ready;
   logic [XLEN-1:0]    i_alu_data;
   logic [XLEN-1:0]    i_rs2_data;
   logic [XLEN-1:0]    i_pc;
   logic [RADDR_W-1:0] i_rd_addr;
   logic               i_rd_wren;
   logic               i_mem_wren;
   logic               i_mem_rden;
   logic [LDT_W-1:0]   i_ld_type;

   logic               o_mem_valid;
   logic               i_mem_ready;
   logic [XLEN-1:0]    o_alu_data;
   logic [XLEN-1:0]    o_rs2_data;
   logic [XLEN-1:0]    o_pc;
   logic [RADDR_W-1:0] o_rd_addr;
   logic               o_rd_wren;
   logic               o_mem_wren;
   logic               o_mem_rden;
   logic [LDT_W-1:0]   o_ld_type;

   logic               o_fwd_valid;
   logic [RADDR_W-1:0] o_fwd_rd;
   logic [XLEN-1:0]    o_fwd_data;

   modport slave (
      input  i_flush, i_ex_valid, i_alu_data, i_rs2_data, i_pc, i_rd_addr,
             i_rd_wren, i_mem_wren, i_mem_rden, i_ld_type, i_mem_ready,
      output o_ex_ready, o_mem_valid, o_alu_data, o_rs2_data, o_pc, o_rd_addr,
             o_rd_wren, o_mem_wren, o_mem_rden, o_ld_type,
             o_fwd_valid, o_fwd_rd, o_fwd_data
   );

   modport master (
      output i_flush, i_ex_valid, i_alu_data, i_rs2_data, i_pc, i_rd_addr,
             i_rd_wren, i_mem_wren, i_mem_rden, i_ld_type, i_mem_ready,
      input  o_ex_ready, o_mem_valid, o_alu_data, o_rs2_data, o_pc, o_rd_addr,
             o_rd_wren, o_mem_wren, o_mem_rden, o_ld_type,
             o_fwd_valid, o_fwd_rd, o_fwd_data
   );

endinterface

// File: rtl/pipe_skid_buf.sv
// Purpose: generic 2-entry valid/ready skid buffer (OUT entry drives the outputs, SKID entry
//          absorbs one extra beat), strict FIFO order, in_ready depends only on state.
// Ports:  clk, rst (async, active-high), flush (drop both entries at next edge),
//         in_valid/in_ready/in_data (upstream), out_valid/out_ready/out_data (downstream).
module pipe_skid_buf #(
   parameter type T = logic
) (
   input  logic clk,
   input  logic rst,
   input  logic flush,
   input  logic in_valid,
   output logic in_ready,
   input  T     in_data,
   output logic out_valid,
   input  logic out_ready,
   output T     out_data
);

   logic out_valid_q, out_valid_d;
   logic skid_valid_q, skid_valid_d;
   T     out_data_q, out_data_d;
   T     skid_data_q, skid_data_d;
   logic accept, drain;

   // Upstream readiness is a pure function of the SKID flop
   assign in_ready  = ~skid_valid_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;

   assign accept = in_valid & ~skid_valid_q;
   assign drain  = out_valid_q & out_ready;

   // Next-state for both entries
   always_comb begin
      out_valid_d  = out_valid_q;
      skid_valid_d = skid_valid_q;
      out_data_d   = out_data_q;
      skid_data_d  = skid_data_q;
      if (flush) begin
         out_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
      end else if (!out_valid_q || drain) begin
         if (skid_valid_q) begin
            // SKID promotes to OUT; accept cannot fire while SKID is held
            out_valid_d  = 1'b1;
            out_data_d   = skid_data_q;
            skid_valid_d = 1'b0;
         end else if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data;
         end else begin
            out_valid_d = 1'b0;
         end
      end else if (accept) begin
         skid_valid_d = 1'b1;
         skid_data_d  = in_data;
      end
   end

   // Entry state registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q  <= 1'b0;
         skid_valid_q <= 1'b0;
         out_data_q   <= '0;
         skid_data_q  <= '0;
      end else begin
         out_valid_q  <= out_valid_d;
         skid_valid_q <= skid_valid_d;
         out_data_q   <= out_data_d;
         skid_data_q  <= skid_data_d;
      end
   end

endmodule

// File: rtl/ex_mem_skid_reg.sv
// Purpose: EX->MEM pipeline boundary. Packs the EX payload, gates rd_wren for x0, buffers it in
//          a 2-entry skid buffer so MEM back-pressure never reaches EX combinationally, and
//          exports the MEM-side entry as an EX->EX forwarding tap.
// Ports:  i_clk, i_rst (async, active-high), bus (ex_mem_skid_reg_if.slave: flush, EX
//         handshake + payload, MEM handshake + payload, forwarding tap).
module ex_mem_skid_reg
   import rv_pipe_pkg::*;
(
   input  logic                i_clk,
   input  logic                i_rst,
   ex_mem_skid_reg_if.slave    bus
);

   ex_mem_pl_t pl_in;
   ex_mem_pl_t pl_out;
   logic       mem_valid;
   logic       ex_ready;

   // Pack EX payload; writes to x0 are never reported as register writes
   always_comb begin
      pl_in          = '0;
      pl_in.alu      = bus.i_alu_data;
      pl_in.rs2      = bus.i_rs2_data;
      pl_in.pc       = bus.i_pc;
      pl_in.rd       = bus.i_rd_addr;
      pl_in.rd_wren  = bus.i_rd_wren & (bus.i_rd_addr != RADDR_W'(0));
      pl_in.mem_wren = bus.i_mem_wren;
      pl_in.mem_rden = bus.i_mem_rden;
      pl_in.ld_type  = bus.i_ld_type;
   end

   pipe_skid_buf #(.T(ex_mem_pl_t)) u_skid (
      .clk       (i_clk),
      .rst       (i_rst),
      .flush     (bus.i_flush),
      .in_valid  (bus.i_ex_valid),
      .in_ready  (ex_ready),
      .in_data   (pl_in),
      .out_valid (mem_valid),
      .out_ready (bus.i_mem_ready),
      .out_data  (pl_out)
   );

   assign bus.o_ex_ready  = ex_ready;
   assign bus.o_mem_valid = mem_valid;
   assign bus.o_alu_data  = pl_out.alu;
   assign bus.o_rs2_data  = pl_out.rs2;
   assign bus.o_pc        = pl_out.pc;
   assign bus.o_rd_addr   = pl_out.rd;
   assign bus.o_rd_wren   = pl_out.rd_wren;
   assign bus.o_mem_wren  = pl_out.mem_wren;
   assign bus.o_mem_rden  = pl_out.mem_rden;
   assign bus.o_ld_type   = pl_out.ld_type;

   // Load results are not available yet, so only non-load writers are forwardable
   assign bus.o_fwd_valid = mem_valid & pl_out.rd_wren & ~pl_out.mem_rden;
   assign bus.o_fwd_rd    = pl_out.rd;
   assign bus.o_fwd_data  = pl_out.alu;

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// Purpose: self-checking bench for ex_mem_skid_reg: directed scenarios with literal
//          expectations plus randomized valid/ready/flush traffic against a queue model.
module tb_ex_mem_skid_reg;
   import rv_pipe_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;

   ex_mem_skid_reg_if bus ();

   ex_mem_skid_reg dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int         checks = 0;
   int         errors = 0;
   bit         cmp_en = 1'b0;
   ex_mem_pl_t mq[$];       // entries held by the block, front = entry shown to MEM
   ex_mem_pl_t cmp_e;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic ex_mem_pl_t zero_pl();
      ex_mem_pl_t p;
      p = '0;
      return p;
   endfunction

   task automatic set_in(input logic v, input ex_mem_pl_t p);
      bus.i_ex_valid = v;
      bus.i_alu_data = p.alu;
      bus.i_rs2_data = p.rs2;
      bus.i_pc       = p.pc;
      bus.i_rd_addr  = p.rd;
      bus.i_rd_wren  = p.rd_wren;
      bus.i_mem_wren = p.mem_wren;
      bus.i_mem_rden = p.mem_rden;
      bus.i_ld_type  = p.ld_type;
   endtask

   function automatic ex_mem_pl_t cur_in();
      ex_mem_pl_t p;
      p.alu      = bus.i_alu_data;
      p.rs2      = bus.i_rs2_data;
      p.pc       = bus.i_pc;
      p.rd       = bus.i_rd_addr;
      p.rd_wren  = bus.i_rd_wren && (bus.i_rd_addr != 0);
      p.mem_wren = bus.i_mem_wren;
      p.mem_rden = bus.i_mem_rden;
      p.ld_type  = bus.i_ld_type;
      return p;
   endfunction

   // Reference model: a FIFO of at most two entries
   task automatic model_edge();
      bit acc, drn;
      if (rst) begin
         mq.delete();
         return;
      end
      acc = bus.i_ex_valid && (mq.size() < 2);
      drn = (mq.size() > 0) && bus.i_mem_ready;
      if (bus.i_flush) mq.delete();
      else begin
         if (drn) void'(mq.pop_front());
         if (acc) mq.push_back(cur_in());
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   // Every-cycle comparison of DUT outputs against the model
   always @(negedge clk) begin
      if (cmp_en && !rst) begin
         chk("mem_valid", 64'(bus.o_mem_valid), 64'(mq.size() > 0));
         chk("ex_ready", 64'(bus.o_ex_ready), 64'(mq.size() < 2));
         if (mq.size() > 0) begin
            cmp_e = mq[0];
            chk("alu_data", 64'(bus.o_alu_data), 64'(cmp_e.alu));
            chk("rs2_data", 64'(bus.o_rs2_data), 64'(cmp_e.rs2));
            chk("pc", 64'(bus.o_pc), 64'(cmp_e.pc));
            chk("rd_addr", 64'(bus.o_rd_addr), 64'(cmp_e.rd));
            chk("rd_wren", 64'(bus.o_rd_wren), 64'(cmp_e.rd_wren));
            chk("mem_wren", 64'(bus.o_mem_wren), 64'(cmp_e.mem_wren));
            chk("mem_rden", 64'(bus.o_mem_rden), 64'(cmp_e.mem_rden));
            chk("ld_type", 64'(bus.o_ld_type), 64'(cmp_e.ld_type));
            chk("fwd_valid", 64'(bus.o_fwd_valid), 64'(cmp_e.rd_wren && !cmp_e.mem_rden));
            chk("fwd_rd", 64'(bus.o_fwd_rd), 64'(cmp_e.rd));
            chk("fwd_data", 64'(bus.o_fwd_data), 64'(cmp_e.alu));
         end else begin
            chk("fwd_valid_empty", 64'(bus.o_fwd_valid), 64'(0));
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      ex_mem_pl_t p;
      logic       r, rdy0;
      int unsigned seq;

      set_in(1'b0, zero_pl());
      bus.i_flush     = 1'b0;
      bus.i_mem_ready = 1'b0;

      // Reset state
      #12;
      chk("rst_mem_valid", 64'(bus.o_mem_valid), 64'(0));
      chk("rst_ex_ready", 64'(bus.o_ex_ready), 64'(1));
      chk("rst_alu", 64'(bus.o_alu_data), 64'(0));
      chk("rst_pc", 64'(bus.o_pc), 64'(0));
      chk("rst_fwd_valid", 64'(bus.o_fwd_valid), 64'(0));
      rst    = 1'b0;
      cmp_en = 1'b1;

      // 1: back-to-back stream with MEM always ready
      bus.i_mem_ready = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         p = zero_pl();
         p.alu = 32'(k); p.rd = 5'd1; p.rd_wren = 1'b1;
         set_in(1'b1, p);
         step();
         chk("t1_alu", 64'(bus.o_alu_data), 64'(k));
         chk("t1_valid", 64'(bus.o_mem_valid), 64'(1));
         chk("t1_ready", 64'(bus.o_ex_ready), 64'(1));
      end
      set_in(1'b0, zero_pl());
      step();
      chk("t1_drained", 64'(bus.o_mem_valid), 64'(0));

      // 2: back-pressure fills SKID, then drains in order
      bus.i_mem_ready = 1'b0;
      p = zero_pl(); p.alu = 32'hA; set_in(1'b1, p);
      step();
      chk("t2_outA", 64'(bus.o_alu_data), 64'hA);
      chk("t2_readyA", 64'(bus.o_ex_ready), 64'(1));
      p.alu = 32'hB; set_in(1'b1, p);
      step();
      chk("t2_ready_full", 64'(bus.o_ex_ready), 64'(0));
      chk("t2_still_A", 64'(bus.o_alu_data), 64'hA);
      set_in(1'b0, zero_pl());
      bus.i_mem_ready = 1'b1;
      step();
      chk("t2_outB", 64'(bus.o_alu_data), 64'hB);
      chk("t2_ready_back", 64'(bus.o_ex_ready), 64'(1));
      step();
      chk("t2_empty", 64'(bus.o_mem_valid), 64'(0));

      // 3: flush with both entries full and EX presenting
      bus.i_mem_ready = 1'b0;
      p = zero_pl(); p.alu = 32'hC; set_in(1'b1, p); step();
      p.alu = 32'hD; set_in(1'b1, p); step();
      chk("t3_full", 64'(bus.o_ex_ready), 64'(0));
      p.alu = 32'hE; set_in(1'b1, p);
      bus.i_flush = 1'b1; bus.i_mem_ready = 1'b1;
      step();
      chk("t3_flush_valid", 64'(bus.o_mem_valid), 64'(0));
      chk("t3_flush_ready", 64'(bus.o_ex_ready), 64'(1));
      bus.i_flush = 1'b0;
      set_in(1'b0, zero_pl());
      step();
      chk("t3_not_captured", 64'(bus.o_mem_valid), 64'(0));

      // 4: rd==0 gating and forwarding tap
      p = zero_pl(); p.alu = 32'h77; p.rd = 5'd0; p.rd_wren = 1'b1;
      set_in(1'b1, p); step();
      chk("t4_x0_wren", 64'(bus.o_rd_wren), 64'(0));
      chk("t4_x0_fwd", 64'(bus.o_fwd_valid), 64'(0));
      p = zero_pl(); p.alu = 32'h1000; p.rd = 5'd5; p.rd_wren = 1'b1;
      p.mem_rden = 1'b1; p.ld_type = LDT_LW;
      set_in(1'b1, p); step();
      chk("t4_load_fwd", 64'(bus.o_fwd_valid), 64'(0));
      chk("t4_load_ldt", 64'(bus.o_ld_type), 64'(2));
      p = zero_pl(); p.alu = 32'h55; p.rd = 5'd5; p.rd_wren = 1'b1;
      set_in(1'b1, p); step();
      chk("t4_add_fwd", 64'(bus.o_fwd_valid), 64'(1));
      chk("t4_add_rd", 64'(bus.o_fwd_rd), 64'(5));
      chk("t4_add_data", 64'(bus.o_fwd_data), 64'h55);
      set_in(1'b0, zero_pl()); step();

      // 5: asynchronous reset while both entries are valid
      bus.i_mem_ready = 1'b0;
      p = zero_pl(); p.alu = 32'hF; p.rs2 = 32'h12; p.pc = 32'h40; p.rd = 5'd3; p.rd_wren = 1'b1;
      set_in(1'b1, p); step();
      p.alu = 32'h6; set_in(1'b1, p); step();
      set_in(1'b0, zero_pl());
      #2;
      rst = 1'b1;
      #1;
      mq.delete();
      chk("t5_valid", 64'(bus.o_mem_valid), 64'(0));
      chk("t5_ready", 64'(bus.o_ex_ready), 64'(1));
      chk("t5_alu", 64'(bus.o_alu_data), 64'(0));
      chk("t5_rs2", 64'(bus.o_rs2_data), 64'(0));
      chk("t5_pc", 64'(bus.o_pc), 64'(0));
      chk("t5_rd", 64'(bus.o_rd_addr), 64'(0));
      chk("t5_fwd", 64'(bus.o_fwd_valid), 64'(0));
      step();
      #2;
      rst = 1'b0;

      // 6: random traffic; pc carries a sequence number to expose loss/dup/reorder
      seq = 1;
      for (int c = 0; c < 10000; c++) begin
         p          = zero_pl();
         p.alu      = $urandom;
         p.rs2      = $urandom;
         p.pc       = 32'(seq);
         p.rd       = 5'($urandom);
         p.rd_wren  = 1'($urandom);
         p.mem_wren = 1'($urandom);
         p.mem_rden = 1'($urandom);
         p.ld_type  = 3'($urandom);
         set_in($urandom_range(0, 3) != 0, p);
         r = ($urandom_range(0, 2) != 0);
         bus.i_flush = ($urandom_range(0, 63) == 0);
         // ex_ready must not react to mem_ready within the cycle
         bus.i_mem_ready = ~r;
         #1;
         rdy0 = bus.o_ex_ready;
         bus.i_mem_ready = r;
         #1;
         chk("t6_ready_indep", 64'(bus.o_ex_ready), 64'(rdy0));
         if (bus.i_ex_valid && (mq.size() < 2) && !bus.i_flush) seq++;
         step();
      end
      bus.i_flush = 1'b0;
      set_in(1'b0, zero_pl());
      bus.i_mem_ready = 1'b1;
      step();
      step();
      cmp_en = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
